// File: rtl/pci_tgt_seq_pkg.sv
// rtl/pci_tgt_seq_pkg.sv - shared command codes, FSM state enum and defaults for the PCI target sequencer
// Contents:
//   CMD_MEM_RD / CMD_MEM_WR  - cbe_ codes accepted during the address phase
//   DEFAULT_BASE_ADDR        - default target window for ad_in[31:20]
//   tgt_state_e              - sequencer states; ST_RETRY exists only with TGT_TIMEOUT_EN
//   is_mem_cmd()             - true for the two commands this target claims
package pci_tgt_seq_pkg;

    localparam logic [3:0]  CMD_MEM_RD        = 4'b0110;
    localparam logic [3:0]  CMD_MEM_WR        = 4'b0111;
    localparam logic [11:0] DEFAULT_BASE_ADDR = 12'h000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
`ifdef TGT_TIMEOUT_EN
        ST_RETRY = 3'd3,
`endif
        ST_SKIP  = 3'd4,
        ST_TURN  = 3'd5
    } tgt_state_e;

    function automatic logic is_mem_cmd(input logic [3:0] cbe);
        return (cbe == CMD_MEM_RD) || (cbe == CMD_MEM_WR);
    endfunction

endpackage

// File: rtl/pci_tgt_seq_timeout.sv
// rtl/pci_tgt_seq_timeout.sv - data-phase wait counter for the PCI target sequencer
// Ports:
//   clk, rst  - rising-edge clock, asynchronous active-high reset
//   clr       - restart the count (data phase entry)
//   inc       - one more data-phase cycle without completion
//   expire    - this increment brings the count to TIMEOUT_CYC-1
module tgt_timeout #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned   CW           = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST     = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] CNT_PRE_LAST = CW'(TIMEOUT_CYC - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Flagged one edge early so the sequencer can register the retry
    // outputs on the same edge the count lands on TIMEOUT_CYC-1.
    assign expire = inc && (cnt_q == CNT_PRE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pci_tgt_seq.sv
// rtl/pci_tgt_seq.sv - single-data-phase PCI memory target sequencer feeding a downstream decoder
// Optional feature: define TGT_TIMEOUT_EN to add the data-phase timeout and RETRY state.
// Ports:
//   clk, rst               - rising-edge clock, asynchronous active-high reset
//   frame_, irdy_          - initiator frame / ready (active-low)
//   cbe_, ad_in            - command/byte enables and address/data from the bus
//   tuvv_ready, rd_data    - decoder can accept a data phase / read data from it
//   valid_pci, a_d         - qualifier for ad_to_tuvv, 1 = address phase
//   ad_to_tuvv             - address or write data to the decoder
//   devsel_, trdy_, stop_  - target bus handshake (active-low)
//   ad_out, ad_oe          - read data onto the bus and its drive enable
//   is_wr                  - direction latched at the address phase
// All outputs are registered: each edge computes the values for the following cycle.
module pci_tgt_seq
    import pci_tgt_seq_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_,
    input  logic        irdy_,
    input  logic [3:0]  cbe_,
    input  logic [31:0] ad_in,
    input  logic        tuvv_ready,
    input  logic [31:0] rd_data,
    output logic        valid_pci,
    output logic        a_d,
    output logic [31:0] ad_to_tuvv,
    output logic        devsel_,
    output logic        trdy_,
    output logic        stop_,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    output logic        is_wr
);

    tgt_state_e  state_q,      state_d;
    logic        frame_prev_q, frame_prev_d;
    logic        is_wr_q,      is_wr_d;
    logic        valid_q,      valid_d;
    logic        a_d_q,        a_d_d;
    logic [31:0] ad_to_q,      ad_to_d;
    logic        devsel_n_q,   devsel_n_d;
    logic        trdy_n_q,     trdy_n_d;
    logic        stop_n_q,     stop_n_d;
    logic [31:0] ad_out_q,     ad_out_d;
    logic        ad_oe_q,      ad_oe_d;

    logic start;
    logic hit;
    logic master_abort;
    logic cmpl;

    // frame_prev resets low, so a frame_ held low across reset never counts as a start.
    assign start        = frame_prev_q && !frame_;
    assign hit          = (ad_in[31:20] == BASE_ADDR) && is_mem_cmd(cbe_);
    assign master_abort = frame_ && irdy_;
    assign cmpl         = !irdy_ && tuvv_ready;

`ifdef TGT_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_inc;
    logic tmo_expire;

    assign tmo_clr = (state_q == ST_ADDR) && !master_abort;
    assign tmo_inc = (state_q == ST_DATA) && !master_abort && !cmpl;

    tgt_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_expire)
    );
`endif

    always_comb begin
        state_d      = state_q;
        frame_prev_d = frame_;
        is_wr_d      = is_wr_q;
        valid_d      = 1'b0;
        a_d_d        = 1'b0;
        ad_to_d      = 32'h0;
        devsel_n_d   = 1'b1;
        trdy_n_d     = 1'b1;
        stop_n_d     = 1'b1;
        ad_out_d     = 32'h0;
        ad_oe_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (hit) begin
                        // The ad_to_tuvv register itself holds the latched address
                        // for the single address-phase cycle.
                        state_d    = ST_ADDR;
                        is_wr_d    = (cbe_ == CMD_MEM_WR);
                        valid_d    = 1'b1;
                        a_d_d      = 1'b1;
                        ad_to_d    = ad_in;
                        devsel_n_d = 1'b0;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_ADDR: begin
                if (master_abort) begin
                    state_d = ST_TURN;
                end else begin
                    state_d    = ST_DATA;
                    devsel_n_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (master_abort) begin
                    state_d = ST_TURN;
                end else if (cmpl) begin
                    state_d    = ST_TURN;
                    valid_d    = 1'b1;
                    devsel_n_d = 1'b0;
                    trdy_n_d   = 1'b0;
                    // Initiator still framing means it wants more: disconnect with data.
                    stop_n_d   = frame_;
                    if (is_wr_q) begin
                        ad_to_d = ad_in;
                    end else begin
                        ad_out_d = rd_data;
                        ad_oe_d  = 1'b1;
                    end
`ifdef TGT_TIMEOUT_EN
                end else if (tmo_expire) begin
                    state_d    = ST_RETRY;
                    devsel_n_d = 1'b0;
                    stop_n_d   = 1'b0;
`endif
                end else begin
                    devsel_n_d = 1'b0;
                end
            end
`ifdef TGT_TIMEOUT_EN
            ST_RETRY: begin
                if (frame_) begin
                    state_d = ST_TURN;
                end else begin
                    devsel_n_d = 1'b0;
                    stop_n_d   = 1'b0;
                end
            end
`endif
            ST_SKIP: begin
                if (frame_ && irdy_) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_prev_q <= 1'b0;
            is_wr_q      <= 1'b0;
            valid_q      <= 1'b0;
            a_d_q        <= 1'b0;
            ad_to_q      <= 32'h0;
            devsel_n_q   <= 1'b1;
            trdy_n_q     <= 1'b1;
            stop_n_q     <= 1'b1;
            ad_out_q     <= 32'h0;
            ad_oe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_prev_q <= frame_prev_d;
            is_wr_q      <= is_wr_d;
            valid_q      <= valid_d;
            a_d_q        <= a_d_d;
            ad_to_q      <= ad_to_d;
            devsel_n_q   <= devsel_n_d;
            trdy_n_q     <= trdy_n_d;
            stop_n_q     <= stop_n_d;
            ad_out_q     <= ad_out_d;
            ad_oe_q      <= ad_oe_d;
        end
    end

    assign valid_pci  = valid_q;
    assign a_d        = a_d_q;
    assign ad_to_tuvv = ad_to_q;
    assign devsel_    = devsel_n_q;
    assign trdy_      = trdy_n_q;
    assign stop_      = stop_n_q;
    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;
    assign is_wr      = is_wr_q;

endmodule

// File: tb/tb_pci_tgt_seq.sv
// tb/tb_pci_tgt_seq.sv - self-checking bench for pci_tgt_seq (directed + randomized transactions)
`timescale 1ns/1ps
module tb_pci_tgt_seq;
    import pci_tgt_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_;
    logic        irdy_;
    logic [3:0]  cbe_;
    logic [31:0] ad_in;
    logic        tuvv_ready;
    logic [31:0] rd_data;
    logic        valid_pci;
    logic        a_d;
    logic [31:0] ad_to_tuvv;
    logic        devsel_;
    logic        trdy_;
    logic        stop_;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        is_wr;

    pci_tgt_seq #(
        .BASE_ADDR   (12'h000),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_     (frame_),
        .irdy_      (irdy_),
        .cbe_       (cbe_),
        .ad_in      (ad_in),
        .tuvv_ready (tuvv_ready),
        .rd_data    (rd_data),
        .valid_pci  (valid_pci),
        .a_d        (a_d),
        .ad_to_tuvv (ad_to_tuvv),
        .devsel_    (devsel_),
        .trdy_      (trdy_),
        .stop_      (stop_),
        .ad_out     (ad_out),
        .ad_oe      (ad_oe),
        .is_wr      (is_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Output snapshot: {valid, a_d, devsel_, trdy_, stop_, ad_oe, ad_to_tuvv, ad_out}
    logic [69:0] obs_vec;
    assign obs_vec = {valid_pci, a_d, devsel_, trdy_, stop_, ad_oe, ad_to_tuvv, ad_out};

    task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] outs(input logic v, input logic ad, input logic dsel,
                                         input logic trdy, input logic stp, input logic oe,
                                         input logic [31:0] to_tuvv, input logic [31:0] aout);
        return {v, ad, dsel, trdy, stp, oe, to_tuvv, aout};
    endfunction

    function automatic logic [69:0] idle_outs();
        return outs(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    endfunction

    function automatic logic [69:0] wait_outs();
        return outs(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    endfunction

    task automatic bus_idle();
        frame_     = 1'b1;
        irdy_      = 1'b1;
        cbe_       = 4'h0;
        ad_in      = $urandom;
        tuvv_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Address phase of a claimed transaction; expects the one-cycle address strobe.
    task automatic addr_phase(input logic [31:0] addr, input logic wr, input logic [31:0] rdv);
        @(negedge clk);
        frame_  = 1'b0;
        irdy_   = 1'b1;
        ad_in   = addr;
        cbe_    = wr ? CMD_MEM_WR : CMD_MEM_RD;
        rd_data = rdv;
        tick();
        check_eq("addr_phase", obs_vec, outs(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, addr, 32'h0));
        check_eq("is_wr", {69'h0, is_wr}, {69'h0, wr});
    endtask

    task automatic run_hit(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                           input logic [31:0] rdv, input int wait_n, input logic hold_frame);
        addr_phase(addr, wr, rdv);
        @(negedge clk);
        frame_     = hold_frame ? 1'b0 : 1'b1;
        irdy_      = 1'b0;
        ad_in      = data;
        cbe_       = 4'h0;
        tuvv_ready = 1'b0;
        tick();
        check_eq("data_wait", obs_vec, wait_outs());
        for (int i = 0; i < wait_n; i++) begin
            tick();
            check_eq("data_wait", obs_vec, wait_outs());
        end
        @(negedge clk);
        tuvv_ready = 1'b1;
        tick();
        check_eq("complete", obs_vec,
                 outs(1'b1, 1'b0, 1'b0, 1'b0, !hold_frame, !wr, wr ? data : 32'h0, wr ? 32'h0 : rdv));
        @(negedge clk);
        bus_idle();
        tick();
        check_eq("turn", obs_vec, idle_outs());
    endtask

    // Start that the target must ignore: outputs stay idle whatever the initiator does.
    task automatic run_miss(input logic [31:0] addr, input logic [3:0] cmd);
        @(negedge clk);
        frame_ = 1'b0;
        irdy_  = 1'b1;
        ad_in  = addr;
        cbe_   = cmd;
        tick();
        check_eq("miss_addr", obs_vec, idle_outs());
        @(negedge clk);
        irdy_      = 1'b0;
        tuvv_ready = 1'b1;
        ad_in      = $urandom;
        cbe_       = CMD_MEM_WR;
        repeat (3) begin
            tick();
            check_eq("miss_data", obs_vec, idle_outs());
        end
        @(negedge clk);
        bus_idle();
        tick();
        check_eq("miss_end", obs_vec, idle_outs());
    endtask

    task automatic run_abort(input logic [31:0] addr, input logic wr);
        addr_phase(addr, wr, $urandom);
        @(negedge clk);
        bus_idle();
        tick();
        check_eq("abort", obs_vec, idle_outs());
        tick();
        check_eq("abort_idle", obs_vec, idle_outs());
    endtask

    initial begin
        rst     = 1'b1;
        rd_data = 32'h0;
        bus_idle();

        repeat (2) tick();
        check_eq("reset_outs", obs_vec, idle_outs());
        check_eq("reset_is_wr", {69'h0, is_wr}, 70'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_eq("post_reset", obs_vec, idle_outs());

        // Write with data, then read, both single-phase; then a disconnect-with-data.
        run_hit(32'h000E0200, 1'b1, 32'h12345678, 32'h0, 0, 1'b0);
        run_hit(32'h000E0204, 1'b0, 32'h0, 32'hCAFE0001, 0, 1'b0);
        run_hit(32'h00000010, 1'b1, 32'hA5A5_0F0F, 32'h0, 2, 1'b1);

        // Outside the window, then an unclaimed command inside it.
        run_miss(32'h00100000, CMD_MEM_WR);
        run_miss(32'h00000040, 4'b0010);

        run_abort(32'h00000100, 1'b0);

        // Reset in the middle of a data phase.
        addr_phase(32'h00000200, 1'b1, 32'h0);
        @(negedge clk);
        frame_     = 1'b0;
        irdy_      = 1'b0;
        ad_in      = 32'h0BAD_0BAD;
        tuvv_ready = 1'b0;
        tick();
        check_eq("pre_reset_wait", obs_vec, wait_outs());
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_reset", obs_vec, idle_outs());
        check_eq("async_reset_is_wr", {69'h0, is_wr}, 70'h0);
        @(negedge clk);
        rst        = 1'b0;
        tuvv_ready = 1'b1;
        cbe_       = CMD_MEM_WR;
        ad_in      = 32'h00000300;
        repeat (4) begin
            tick();
            check_eq("no_restart", obs_vec, idle_outs());
        end
        @(negedge clk);
        bus_idle();
        tick();
        run_hit(32'h00000304, 1'b1, 32'h5555_AAAA, 32'h0, 1, 1'b0);

`ifdef TGT_TIMEOUT_EN
        addr_phase(32'h00000400, 1'b0, 32'h77);
        @(negedge clk);
        frame_     = 1'b0;
        irdy_      = 1'b0;
        tuvv_ready = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_eq("tmo_wait", obs_vec, wait_outs());
        end
        tick();
        check_eq("tmo_retry", obs_vec, outs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
        tick();
        check_eq("tmo_retry_hold", obs_vec, outs(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0));
        @(negedge clk);
        bus_idle();
        tick();
        check_eq("tmo_release", obs_vec, idle_outs());
        tick();
        check_eq("tmo_idle", obs_vec, idle_outs());
`else
        // Without the timeout the target waits on the decoder indefinitely.
        run_hit(32'h00000400, 1'b0, 32'h0, 32'h0000_7777, 40, 1'b1);
`endif

        for (int n = 0; n < 24; n++) begin
            int unsigned kind;
            logic [31:0] hit_addr;
            logic [3:0]  bad_cmd;
            kind     = $urandom_range(0, 4);
            hit_addr = {12'h000, 20'($urandom)};
            case (kind)
                0, 1: run_hit(hit_addr, kind == 0, $urandom, $urandom,
                              $urandom_range(0, 4), 1'($urandom_range(0, 1)));
                2: run_miss({12'($urandom_range(1, 4095)), 20'($urandom)}, CMD_MEM_RD);
                3: begin
                    bad_cmd = 4'($urandom);
                    if (is_mem_cmd(bad_cmd)) bad_cmd = 4'b1100;
                    run_miss(hit_addr, bad_cmd);
                end
                default: run_abort(hit_addr, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
